// File: rtl/lpc_algorithm_sequencer.sv
// LPC algorithm sequencer: frame capture, then autocorrelation, then Levinson-Durbin.
// Avalon-MM slave with CTRL / STATUS / FRAME_LEN / SAMPLE_COUNT registers.
// Optional stage watchdog selected by the LPC_SEQ_TIMEOUT_EN macro.
module lpc_algorithm_sequencer #(
  parameter int unsigned DEFAULT_FRAME_LEN = 240,
  parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        start_in,
  input  logic        sample_valid,
  output logic        ac_start,
  input  logic        ac_done,
  output logic        ld_start,
  input  logic        ld_done,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_AC_WAIT = 2'd2,
    S_LD_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_len_q, frame_len_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               irq_en_q, irq_en_d;
  logic               ac_start_d, ld_start_d, busy_d, irq_d;
  logic               start_sync_q, start_prev_q, start_armed_q;

  logic wr_en, ctrl_wr, status_wr, flen_wr;
  logic start_edge, start_req, abort_req, go;
  logic last_sample, ac_ok, ld_ok, in_wait, tmo_hit, tmo_fire;
  logic unused_ok;

  assign unused_ok = ^{writedata[31:12], 32'(TIMEOUT_CYCLES)};

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en && (address == 2'd0);
  assign status_wr = wr_en && (address == 2'd1);
  assign flen_wr   = wr_en && (address == 2'd2);

  // The armed flag blocks an edge until start_in has been seen low after reset.
  assign start_edge  = start_armed_q & start_sync_q & ~start_prev_q;
  assign start_req   = (ctrl_wr & writedata[0]) | start_edge;
  assign abort_req   = ctrl_wr & writedata[1];
  assign go          = start_req & ~abort_req & (state_q == S_IDLE);
  assign last_sample = sample_valid && (count_q == frame_len_q - CNT_W'(1));
  assign ac_ok       = (state_q == S_AC_WAIT) & ac_done & ~ac_start;
  assign ld_ok       = (state_q == S_LD_WAIT) & ld_done & ~ld_start;
  assign in_wait     = (state_q == S_AC_WAIT) || (state_q == S_LD_WAIT);
  assign tmo_fire    = in_wait & tmo_hit & ~ac_ok & ~ld_ok & ~abort_req;

`ifdef LPC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Stage watchdog: restarts on wait-state entry, counts while waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if ((state_d != state_q) &&
                 ((state_d == S_AC_WAIT) || (state_d == S_LD_WAIT))) begin
      tmo_cnt_q <= '0;
    end else if (in_wait) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Start request synchroniser and edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_sync_q  <= 1'b0;
      start_prev_q  <= 1'b0;
      start_armed_q <= 1'b0;
    end else begin
      start_sync_q  <= start_in;
      start_prev_q  <= start_sync_q;
      start_armed_q <= start_armed_q | ~start_in;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort_req) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (start_req) state_d = S_CAPTURE;
        S_CAPTURE: if (last_sample) state_d = S_AC_WAIT;
        S_AC_WAIT: if (ac_ok) state_d = S_LD_WAIT;
                   else if (tmo_hit) state_d = S_IDLE;
        S_LD_WAIT: if (ld_ok) state_d = S_IDLE;
                   else if (tmo_hit) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Next values of registers and registered outputs
  always_comb begin
    done_d      = done_q;
    timeout_d   = timeout_q;
    irq_en_d    = irq_en_q;
    frame_len_d = frame_len_q;
    count_d     = count_q;
    if (ctrl_wr) irq_en_d = writedata[2];
    if (flen_wr && (state_q == S_IDLE)) frame_len_d = writedata[CNT_W-1:0];
    if (status_wr && writedata[1]) done_d = 1'b0;
    if (status_wr && writedata[2]) timeout_d = 1'b0;
    if (go) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      count_d   = '0;
    end
    if ((state_q == S_CAPTURE) && sample_valid && !abort_req) count_d = count_q + CNT_W'(1);
    if (ld_ok && !abort_req) done_d = 1'b1;
    if (tmo_fire) timeout_d = 1'b1;
    ac_start_d = (state_q != S_AC_WAIT) && (state_d == S_AC_WAIT);
    ld_start_d = (state_q != S_LD_WAIT) && (state_d == S_LD_WAIT);
    busy_d     = (state_d != S_IDLE);
    irq_d      = irq_en_d & (done_d | timeout_d);
  end

  // Register file and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      frame_len_q <= CNT_W'(DEFAULT_FRAME_LEN);
      count_q     <= '0;
      ac_start    <= 1'b0;
      ld_start    <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
    end else begin
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      irq_en_q    <= irq_en_d;
      frame_len_q <= frame_len_d;
      count_q     <= count_d;
      ac_start    <= ac_start_d;
      ld_start    <= ld_start_d;
      busy        <= busy_d;
      irq         <= irq_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[2]   = irq_en_q;
      2'd1: readdata[5:0] = {1'b0, state_q, timeout_q, done_q, busy};
      2'd2: readdata[CNT_W-1:0] = frame_len_q;
      2'd3: readdata[CNT_W-1:0] = count_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lpc_algorithm_sequencer.sv
// Scoreboard bench for lpc_algorithm_sequencer: stimulus pushes expected
// events (register reads, ac_start/ld_start pulses with cycle stamp) and a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_lpc_algorithm_sequencer;

  localparam logic [1:0] K_RD = 2'd0, K_AC = 2'd1, K_LD = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [33:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        start_in, sample_valid, ac_start, ac_done, ld_start, ld_done, busy, irq;
  logic        rd_chk;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  lpc_algorithm_sequencer #(.DEFAULT_FRAME_LEN(240), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .start_in(start_in), .sample_valid(sample_valid), .ac_start(ac_start),
    .ac_done(ac_done), .ld_start(ld_start), .ld_done(ld_done), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_evt(input logic [1:0] kind, input logic [33:0] val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d got=%h (nothing expected) cyc=%0d", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL %s: got kind=%0d val=%h, expected kind=%0d val=%h", e.name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every DUT output event consumes one expectation
  always @(negedge clk) begin
    if (ac_start) check_evt(K_AC, 34'(cyc));
    if (ld_start) check_evt(K_LD, 34'(cyc));
    if (rd_chk)   check_evt(K_RD, {irq, busy, readdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [33:0] v, input string n);
    q.push_back('{kind: k, val: v, name: n});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic b, input logic i, input string n);
    push(K_RD, {i, b, d}, n);
    address = a; chipselect = 1'b1; write_n = 1'b1; rd_chk = 1'b1;
    tick();
    chipselect = 1'b0; rd_chk = 1'b0;
  endtask

  // n samples back to back; optionally the last one must launch ac_start
  task automatic samples(input int n, input bit expect_ac, input string nm);
    for (int i = 0; i < n; i++) begin
      if (expect_ac && i == n - 1) push(K_AC, 34'(cyc + 1), nm);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_ac_done(input string nm);
    push(K_LD, 34'(cyc + 1), nm);
    ac_done = 1'b1;
    tick();
    ac_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    start_in = 1'b0; sample_valid = 1'b0; ac_done = 1'b0; ld_done = 1'b0; rd_chk = 1'b0;
    repeat (2) tick();
    rd(2'd0, 32'h0,   1'b0, 1'b0, "rst_ctrl");
    rd(2'd1, 32'h0,   1'b0, 1'b0, "rst_status");
    rd(2'd2, 32'd240, 1'b0, 1'b0, "rst_frame_len");
    rd(2'd3, 32'h0,   1'b0, 1'b0, "rst_count");
    reset_n = 1'b1;
    repeat (3) tick();

    // Basic sequence started by the PIO edge
    wr(2'd2, 32'd4);
    rd(2'd2, 32'd4, 1'b0, 1'b0, "t1_frame_len");
    start_in = 1'b1;
    repeat (2) tick();
    rd(2'd1, 32'h09, 1'b1, 1'b0, "t1_capture");
    samples(4, 1'b1, "t1_ac_start");
    repeat (2) tick();
    pulse_ac_done("t1_ld_start");
    tick();
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    rd(2'd1, 32'h02, 1'b0, 1'b0, "t1_status_done");
    rd(2'd3, 32'd4,  1'b0, 1'b0, "t1_count");
    start_in = 1'b0;
    tick();

    // Interrupt, and done inputs ignored in the start-pulse cycle
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h4, 1'b0, 1'b1, "t2_irq_pending");
    wr(2'd0, 32'h5);
    rd(2'd1, 32'h09, 1'b1, 1'b0, "t2_restart");
    samples(4, 1'b1, "t2_ac_start");
    ac_done = 1'b1; tick(); ac_done = 1'b0;
    rd(2'd1, 32'h11, 1'b1, 1'b0, "t2_ac_done_early");
    pulse_ac_done("t2_ld_start");
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    rd(2'd1, 32'h19, 1'b1, 1'b0, "t2_ld_done_early");
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    rd(2'd1, 32'h02, 1'b0, 1'b1, "t2_irq_set");
    wr(2'd1, 32'h2);
    rd(2'd1, 32'h00, 1'b0, 1'b0, "t2_irq_cleared");

    // Abort mid-capture
    wr(2'd0, 32'h1);
    samples(2, 1'b0, "");
    wr(2'd0, 32'h2);
    rd(2'd1, 32'h00, 1'b0, 1'b0, "t3_abort_idle");
    rd(2'd3, 32'd2,  1'b0, 1'b0, "t3_count_held");
    repeat (6) tick();

    // Abort+start together, and writes/starts while busy
    wr(2'd0, 32'h3);
    rd(2'd1, 32'h00, 1'b0, 1'b0, "t4_abort_wins");
    rd(2'd3, 32'd2,  1'b0, 1'b0, "t4_count_untouched");
    wr(2'd0, 32'h1);
    samples(1, 1'b0, "");
    wr(2'd2, 32'd9);
    rd(2'd2, 32'd4, 1'b1, 1'b0, "t4_frame_len_busy");
    wr(2'd0, 32'h1);
    rd(2'd3, 32'd1, 1'b1, 1'b0, "t4_start_busy");
    start_in = 1'b1;
    repeat (3) tick();
    rd(2'd1, 32'h09, 1'b1, 1'b0, "t4_pio_busy");
    start_in = 1'b0;
    samples(3, 1'b1, "t4_ac_start");
    tick();
    pulse_ac_done("t4_ld_start");
    tick();
    ld_done = 1'b1; address = 2'd1; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
    tick();
    ld_done = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    rd(2'd1, 32'h02, 1'b0, 1'b0, "t4_done_set_wins");

    // Withheld ac_done
    wr(2'd0, 32'h1);
    samples(4, 1'b1, "t5_ac_start");
    repeat (20) tick();
`ifdef LPC_SEQ_TIMEOUT_EN
    rd(2'd1, 32'h04, 1'b0, 1'b0, "t5_timeout");
`else
    rd(2'd1, 32'h11, 1'b1, 1'b0, "t5_still_waiting");
`endif
    wr(2'd0, 32'h2);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h00, 1'b0, 1'b0, "t5_cleared");

    // FRAME_LEN=0 means 4096 samples; reset in LD_WAIT; start_in across reset
    wr(2'd2, 32'h0);
    rd(2'd2, 32'h0, 1'b0, 1'b0, "t6_frame_len_zero");
    wr(2'd0, 32'h1);
    samples(4096, 1'b1, "t6_ac_start_4096");
    tick();
    pulse_ac_done("t6_ld_start");
    tick();
    reset_n = 1'b0;
    rd(2'd1, 32'h00,  1'b0, 1'b0, "t6_reset_status");
    rd(2'd2, 32'd240, 1'b0, 1'b0, "t6_reset_frame_len");
    start_in = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    rd(2'd1, 32'h00, 1'b0, 1'b0, "t6_no_start_after_reset");
    start_in = 1'b0;
    repeat (2) tick();
    start_in = 1'b1;
    repeat (2) tick();
    rd(2'd1, 32'h09, 1'b1, 1'b0, "t6_pio_rearmed");
    wr(2'd0, 32'h2);
    repeat (3) tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected events never seen, first=%s", q.size(), q[0].name);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
